// File: rtl/cic_decimator_param.sv
// N-stage CIC decimator with a run-time power-of-two ratio, unity DC gain scaling,
// and a single-entry valid/ready output register with a sticky overwrite flag.
module cic_decimator_param #(
    parameter int N        = 3,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8,
    parameter int RLOG_MAX = 4,
    localparam int ACC_W   = IN_W + N * RLOG_MAX,
    localparam int DL_W    = $clog2(RLOG_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [DL_W-1:0]  dec_log2,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             overflow
);

    localparam logic [DL_W-1:0] DL_MAX = DL_W'(RLOG_MAX);
    localparam int SH_W = $clog2(ACC_W);

    logic [DL_W-1:0]     dl_clamped;
    logic [DL_W-1:0]     dec_log2_reg;
    logic [RLOG_MAX-1:0] cnt_reg;
    logic [RLOG_MAX-1:0] cnt_last;
    logic [ACC_W-1:0]    x_ext;
    logic [ACC_W-1:0]    integ_reg  [N];
    logic [ACC_W-1:0]    integ_next [N];
    logic [ACC_W-1:0]    prev_reg   [N];
    logic [ACC_W-1:0]    comb_val   [N+1];
    logic [SH_W-1:0]     shift_amt;
    logic                decim;
    logic [OUT_W-1:0]    out_data_reg;
    logic                out_valid_reg;
    logic                overflow_reg;

    assign dl_clamped = (dec_log2 > DL_MAX) ? DL_MAX : dec_log2;
    assign cnt_last   = RLOG_MAX'((32'd1 << dec_log2_reg) - 32'd1);
    assign x_ext      = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign decim      = in_valid && !cfg_load && (cnt_reg == cnt_last);
    // Dropping N*dec_log2 bits undoes the R^N CIC gain; the rest trims IN_W down to OUT_W.
    assign shift_amt  = SH_W'(N * int'(dec_log2_reg) + IN_W - OUT_W);

    // Integrator cascade sees this cycle's sample ripple through every stage.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_integ
            if (gi == 0) begin : g_first
                assign integ_next[gi] = integ_reg[gi] + x_ext;
            end else begin : g_rest
                assign integ_next[gi] = integ_reg[gi] + integ_next[gi-1];
            end
        end
    endgenerate

    assign comb_val[0] = integ_next[N-1];
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_comb
            assign comb_val[gi+1] = comb_val[gi] - prev_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            for (int k = 0; k < N; k++) begin
                integ_reg[k] <= '0;
                prev_reg[k]  <= '0;
            end
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            dec_log2_reg  <= dl_clamped;
            if (rst) begin
                out_data_reg <= '0;
            end
        end else begin
            if (in_valid) begin
                for (int k = 0; k < N; k++) begin
                    integ_reg[k] <= integ_next[k];
                end
                cnt_reg <= decim ? '0 : cnt_reg + 1'b1;
            end
            if (decim) begin
                for (int k = 0; k < N; k++) begin
                    prev_reg[k] <= comb_val[k];
                end
                out_data_reg  <= comb_val[N][shift_amt +: OUT_W];
                out_valid_reg <= 1'b1;
                if (out_valid_reg && !out_ready) begin
                    overflow_reg <= 1'b1;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign overflow  = overflow_reg;

endmodule
